aes_dec_round_ctrl: RTL and testbench
=====================================

Name: aes_dec_round_ctrl

Overview:
- Iterative AES-128 decryption controller: accepts one 128-bit ciphertext block and runs the inverse cipher at one round per clock.
- Sequences InvShiftRows, InvSubBytes, AddRoundKey and inv_mixcolumns over a single state register.
- Fetches round keys 10..0 from the key-schedule store by index.
- Sits between the AXI register wrapper and the existing inverse round datapath.

Parameters:
- NR, 10, number of rounds (AES-128 only; other values unsupported)
- KEY_IDX_W, 4, width of round-key index

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- key_ready  in  1  key schedule complete and stable
- in_valid  in  1  ciphertext valid
- in_ready  out  1  controller accepts ciphertext
- in_data  in  128  ciphertext, byte s0 in [127:120], column-major (s0..s3 = column 0)
- rk_idx  out  KEY_IDX_W  round-key index requested
- rk_data  in  128  round key for rk_idx, combinational same-cycle
- out_valid  out  1  plaintext valid
- out_ready  in  1  consumer accepts plaintext
- out_data  out  128  plaintext, same byte order as in_data
- busy  out  1  high in ROUND, FINAL, DONE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, state_reg=0, round=0, out_valid=0, out_data=0, busy=0, rk_idx=NR.
- FSM states: IDLE, ROUND, FINAL, DONE.
- in_ready = (state==IDLE) & key_ready. Only combinational output path.
- IDLE:
  - rk_idx=NR.
  - On in_valid&in_ready: state_reg <= in_data ^ rk_data, round <= NR-1, go to ROUND.
- ROUND:
  - rk_idx=round.
  - Each edge: state_reg <= InvMixColumns(InvSubBytes(InvShiftRows(state_reg)) ^ rk_data); round <= round-1.
  - When round==1 this edge, go to FINAL.
- FINAL:
  - rk_idx=0.
  - state_reg <= InvSubBytes(InvShiftRows(state_reg)) ^ rk_data; out_valid <= 1; go to DONE.
- DONE:
  - out_data = state_reg, held stable while out_valid & !out_ready.
  - On out_ready: out_valid <= 0, go to IDLE.
- Latency: out_valid rises 10 edges after the accepting edge. Throughput is at most one block per 12 cycles; no back-to-back accept in DONE.
- key_ready dropping mid-operation: ignored. Operation completes with the keys presented; the key store must not change while busy.
- in_valid during ROUND/FINAL/DONE: not accepted; in_ready=0.
- out_ready high before out_valid: no effect.
- Reset mid-operation: block is discarded, outputs return to reset values, and no partial out_valid is produced.
- round counter: 4-bit, never wraps; FINAL is entered from round==1.

Optional Feature:
- Macro AES_DEC_STATUS_EN.
- Defined:
  - Adds output blk_cnt[31:0], reset 0, incremented on each out_valid&out_ready handshake, wraps at 2^32.
  - Adds output err_sticky[0:0], reset 0, set when in_valid is high with key_ready low in IDLE, cleared only by reset.
- Undefined: neither port exists and behaviour is otherwise identical.

Decomposition:
- Package aes_pkg:
  - NR=10 and KEY_IDX_W constants.
  - FSM state enum (IDLE, ROUND, FINAL, DONE).
  - Inverse S-box function and byte-order helper for state<->column mapping.
- Sub-module aes_inv_round (combinational):
  - Inputs: state, rk, is_final.
  - Chains inv_shiftrows, inv_subbytes, AddRoundKey and the existing inv_mixcolumns; is_final bypasses inv_mixcolumns.
- Controller holds only FSM, counter, registers and handshake logic.

Test Plan:
- FIPS-197 C.1 decrypt:
  - Stimulus: key schedule of 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Response: out_data 00112233445566778899aabbccddeeff, out_valid exactly 10 edges after accept, rk_idx sequence 10,9,...,1,0.
- Backpressure:
  - Stimulus: hold out_ready=0 for 20 cycles after out_valid.
  - Response: out_data stable, in_ready=0, busy=1; one cycle after out_ready=1 the FSM is in IDLE and in_ready=1.
- Key gating:
  - Stimulus: key_ready=0 with in_valid=1 for 5 cycles.
  - Response: no accept, busy=0; with STATUS_EN, err_sticky=1 and blk_cnt=0.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 at round 5 for 1 cycle.
  - Response: out_valid=0, out_data=0, rk_idx=10, then a fresh C.1 block decrypts correctly.
- Back-to-back:
  - Stimulus: 4 C.1 blocks with out_ready tied 1.
  - Response: 4 correct outputs, 12-cycle spacing; with STATUS_EN, blk_cnt=4.
- Random:
  - Stimulus: 1000 random keys/ciphertexts from the encrypt reference model.
  - Response: every plaintext matches the model.

Source files
------------

// File: rtl/aes_dec_round_ctrl_pkg.sv
// Shared constants, FSM encoding and byte-level helpers for the AES-128 inverse cipher.
// State bytes are numbered s0..s15 column-major with s0 in bits [127:120].
package aes_pkg;

   localparam int NR        = 10;
   localparam int KEY_IDX_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      ROUND,
      FINAL,
      DONE
   } state_e;

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      return INV_SBOX[x];
   endfunction

   function automatic logic [7:0] get_byte(input logic [127:0] s, input int idx);
      return s[127-8*idx -: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Multiply by a 4-bit GF(2^8) constant, enough for the 09/0b/0d/0e coefficients.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
      logic [7:0] a2, a4, a8;
      a2 = xtime(a);
      a4 = xtime(a2);
      a8 = xtime(a4);
      return ({8{k[0]}} & a) ^ ({8{k[1]}} & a2) ^ ({8{k[2]}} & a4) ^ ({8{k[3]}} & a8);
   endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless is_final selects the last-round form.
module aes_inv_round
   import aes_pkg::*;
(
   input  logic [127:0] state,
   input  logic [127:0] rk,
   input  logic         is_final,
   output logic [127:0] state_out
);

   logic [127:0] shifted_sub;
   logic [127:0] ark;
   logic [127:0] mixed;

   // Row r of column c comes from column (c - r) mod 4 of the input.
   always_comb begin
      shifted_sub = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            shifted_sub[127-8*(4*c+r) -: 8] = inv_sbox(get_byte(state, 4*((c+4-r)%4)+r));
         end
      end
   end

   assign ark = shifted_sub ^ rk;

   always_comb begin
      mixed = '0;
      for (int c = 0; c < 4; c++) begin
         mixed[127-32*c -: 8] = gf_mul(get_byte(ark, 4*c), 4'he) ^ gf_mul(get_byte(ark, 4*c+1), 4'hb)
                              ^ gf_mul(get_byte(ark, 4*c+2), 4'hd) ^ gf_mul(get_byte(ark, 4*c+3), 4'h9);
         mixed[119-32*c -: 8] = gf_mul(get_byte(ark, 4*c), 4'h9) ^ gf_mul(get_byte(ark, 4*c+1), 4'he)
                              ^ gf_mul(get_byte(ark, 4*c+2), 4'hb) ^ gf_mul(get_byte(ark, 4*c+3), 4'hd);
         mixed[111-32*c -: 8] = gf_mul(get_byte(ark, 4*c), 4'hd) ^ gf_mul(get_byte(ark, 4*c+1), 4'h9)
                              ^ gf_mul(get_byte(ark, 4*c+2), 4'he) ^ gf_mul(get_byte(ark, 4*c+3), 4'hb);
         mixed[103-32*c -: 8] = gf_mul(get_byte(ark, 4*c), 4'hb) ^ gf_mul(get_byte(ark, 4*c+1), 4'hd)
                              ^ gf_mul(get_byte(ark, 4*c+2), 4'h9) ^ gf_mul(get_byte(ark, 4*c+3), 4'he);
      end
   end

   assign state_out = is_final ? ark : mixed;

endmodule

// File: rtl/aes_dec_round_ctrl.sv
// Iterative AES-128 decryption controller, one inverse round per clock over one state register.
// Optional status outputs blk_cnt/err_sticky are built when AES_DEC_STATUS_EN is defined.
module aes_dec_round_ctrl
   import aes_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 key_ready,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [127:0]         in_data,
   output logic [KEY_IDX_W-1:0] rk_idx,
   input  logic [127:0]         rk_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [127:0]         out_data,
   output logic                 busy
`ifdef AES_DEC_STATUS_EN
   ,
   output logic [31:0]          blk_cnt,
   output logic [0:0]           err_sticky
`endif
);

   localparam logic [KEY_IDX_W-1:0] NR_IDX = KEY_IDX_W'(NR);

   state_e               state, state_nxt;
   logic [127:0]         state_reg, state_reg_nxt;
   logic [KEY_IDX_W-1:0] round, round_nxt;
   logic [127:0]         round_out;
   logic                 accept;

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // out_valid/out_data stay put until that edge, and in_ready never waits on in_valid.
   assign in_ready  = (state == IDLE) & key_ready;
   assign accept    = in_valid & in_ready;
   assign out_valid = (state == DONE);
   assign out_data  = out_valid ? state_reg : '0;
   assign busy      = (state != IDLE);

   aes_inv_round u_inv_round (
      .state     (state_reg),
      .rk        (rk_data),
      .is_final  (state == FINAL),
      .state_out (round_out)
   );

   always_comb begin
      state_nxt     = state;
      state_reg_nxt = state_reg;
      round_nxt     = round;
      rk_idx        = NR_IDX;
      case (state)
         IDLE: begin
            if (accept) begin
               state_reg_nxt = in_data ^ rk_data;
               round_nxt     = NR_IDX - KEY_IDX_W'(1);
               state_nxt     = ROUND;
            end
         end
         ROUND: begin
            rk_idx        = round;
            state_reg_nxt = round_out;
            round_nxt     = round - KEY_IDX_W'(1);
            if (round == KEY_IDX_W'(1)) state_nxt = FINAL;
         end
         FINAL: begin
            rk_idx        = '0;
            state_reg_nxt = round_out;
            state_nxt     = DONE;
         end
         DONE: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         state_reg <= '0;
         round     <= '0;
      end else begin
         state     <= state_nxt;
         state_reg <= state_reg_nxt;
         round     <= round_nxt;
      end
   end

`ifdef AES_DEC_STATUS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blk_cnt    <= '0;
         err_sticky <= '0;
      end else begin
         if (out_valid && out_ready) blk_cnt <= blk_cnt + 32'd1;
         if ((state == IDLE) && in_valid && !key_ready) err_sticky <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Bench for aes_dec_round_ctrl: a forward AES-128 reference produces ciphertexts whose
// plaintexts are queued; a per-cycle monitor predicts handshakes, key indices and timing.
module tb_aes_dec_round_ctrl;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         key_ready;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic [3:0]   rk_idx;
   logic [127:0] rk_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         busy;
`ifdef AES_DEC_STATUS_EN
   logic [31:0]  blk_cnt;
   logic [0:0]   err_sticky;
`endif

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic [127:0] rk_mem [16];
   logic [7:0]   sbox_t [256];
   logic [127:0] cur_pt;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // monitor / scoreboard state
   logic [127:0] exp_q[$];
   logic [3:0]   rk_log[$];
   bit           m_idle = 1'b1;
   int           m_phase = 0;
   logic [31:0]  m_blk = '0;
   logic         m_err = 1'b0;
   bit           prev_ov = 1'b0;
   int           dut_acc_edge = 0;
   int           last_lat = -1;
   int           last_space = -1;
   int           acc_count = 0;
   int           hs_count = 0;
   logic [127:0] last_out = '0;

   aes_dec_round_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_ready  (key_ready),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .rk_idx     (rk_idx),
      .rk_data    (rk_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
`ifdef AES_DEC_STATUS_EN
      .blk_cnt    (blk_cnt),
      .err_sticky (err_sticky),
`endif
      .busy       (busy)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   assign rk_data = rk_mem[rk_idx];

   // ---------------- reference model ----------------
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = 8'h00; aa = a; bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = xt(aa);
         bb = bb >> 1;
      end
      return p;
   endfunction

   // S-box from first principles: multiplicative inverse then the affine map.
   task automatic build_sbox();
      logic [7:0] inv, b;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
         sbox_t[x] = b;
      end
   endtask

   task automatic expand(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] encrypt(input logic [127:0] pt);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [127:0] v;
      v = pt ^ rk_mem[0];
      for (int rd = 1; rd <= 10; rd++) begin
         for (int i = 0; i < 16; i++) s[i] = sbox_t[v[127-8*i -: 8]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
         for (int c = 0; c < 4; c++) begin
            if (rd < 10) begin
               s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
               s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
               s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
               s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
            end else begin
               for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
            end
         end
         for (int i = 0; i < 16; i++) v[127-8*i -: 8] = s[i] ^ rk_mem[rd][127-8*i -: 8];
      end
      return v;
   endfunction

   // ---------------- scoreboard helpers ----------------
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Per-cycle monitor: compare against the model, then advance it with the inputs
   // that the coming rising edge will sample.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_out_valid", 128'(out_valid), 128'(0));
         chk("rst_out_data", out_data, 128'(0));
         chk("rst_busy", 128'(busy), 128'(0));
         chk("rst_rk_idx", 128'(rk_idx), 128'(10));
         m_idle = 1'b1; m_phase = 0; m_blk = '0; m_err = 1'b0; prev_ov = 1'b0;
         exp_q.delete();
      end else begin
         chk("in_ready", 128'(in_ready), 128'(m_idle && key_ready));
         chk("busy", 128'(busy), 128'(!m_idle));
         chk("out_valid", 128'(out_valid), 128'(!m_idle && m_phase == 10));
         if (m_idle) chk("rk_idx_idle", 128'(rk_idx), 128'(10));
         else if (m_phase <= 9) chk("rk_idx_round", 128'(rk_idx), 128'(9 - m_phase));
         if (!m_idle && m_phase == 10) begin
            if (exp_q.size() == 0) chk("exp_q_nonempty", 128'(0), 128'(1));
            else chk("out_data", out_data, exp_q[0]);
         end
`ifdef AES_DEC_STATUS_EN
         chk("blk_cnt", 128'(blk_cnt), 128'(m_blk));
         chk("err_sticky", 128'(err_sticky), 128'(m_err));
`endif
         if (out_valid) last_out = out_data;
         if (out_valid && !prev_ov) last_lat = cyc - dut_acc_edge;
         prev_ov = out_valid;
         if (in_valid && in_ready) begin
            last_space   = cyc + 1 - dut_acc_edge;
            dut_acc_edge = cyc + 1;
            acc_count++;
         end
         if (m_idle) begin
            if (in_valid && !key_ready) m_err = 1'b1;
            if (in_valid && key_ready) begin
               m_idle = 1'b0; m_phase = 0;
               exp_q.push_back(cur_pt);
               rk_log.delete();
               rk_log.push_back(rk_idx);
            end
         end else if (m_phase < 10) begin
            rk_log.push_back(rk_idx);
            m_phase++;
         end else if (out_ready) begin
            m_idle = 1'b1;
            void'(exp_q.pop_front());
            m_blk = m_blk + 32'd1;
            hs_count++;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_block(input logic [127:0] ct, input logic [127:0] pt);
      bit got;
      got = 1'b0;
      in_data = ct; cur_pt = pt; in_valid = 1'b1;
      for (int n = 0; n < 40 && !got; n++) begin
         @(negedge clk);
         got = in_ready;
         tick();
      end
      in_valid = 1'b0;
      if (!got) chk("accept_timeout", 128'(0), 128'(1));
   endtask

   task automatic wait_done(input bit rnd);
      bit got;
      got = 1'b0;
      for (int n = 0; n < 80 && !got; n++) begin
         if (rnd) out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         got = out_valid && out_ready;
         tick();
      end
      if (!got) chk("done_timeout", 128'(0), 128'(1));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int a0, h0;
      logic [127:0] key, pt, ct;
      rst_n = 1'b0; key_ready = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; cur_pt = '0;
      for (int i = 0; i < 16; i++) rk_mem[i] = '0;

      // pin the reference model to published values
      build_sbox();
      chk("sbox_00", 128'(sbox_t[8'h00]), 128'(8'h63));
      chk("sbox_53", 128'(sbox_t[8'h53]), 128'(8'hed));
      expand(C1_KEY);
      chk("c1_rk10", rk_mem[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
      chk("c1_encrypt", encrypt(C1_PT), C1_CT);

      repeat (3) tick();
      rst_n = 1'b1;
      chk("post_rst_out_data", out_data, 128'(0));
      chk("post_rst_rk_idx", 128'(rk_idx), 128'(10));
      tick();

      // key gating: valid input while keys are not ready
      key_ready = 1'b0; in_valid = 1'b1; in_data = C1_CT; cur_pt = C1_PT;
      repeat (5) tick();
      chk("gate_busy", 128'(busy), 128'(0));
      chk("gate_in_ready", 128'(in_ready), 128'(0));
`ifdef AES_DEC_STATUS_EN
      chk("gate_err_sticky", 128'(err_sticky), 128'(1));
      chk("gate_blk_cnt", 128'(blk_cnt), 128'(0));
`endif
      in_valid = 1'b0; key_ready = 1'b1;
      tick();

      // FIPS-197 C.1
      out_ready = 1'b1;
      send_block(C1_CT, C1_PT);
      wait_done(1'b0);
      chk("c1_plaintext", last_out, C1_PT);
      chk("c1_latency", 128'(last_lat), 128'(10));
      chk("c1_rk_log_len", 128'(rk_log.size()), 128'(11));
      for (int i = 0; i < rk_log.size(); i++) chk("c1_rk_seq", 128'(rk_log[i]), 128'(10 - i));

      // backpressure on the output
      out_ready = 1'b0;
      send_block(C1_CT, C1_PT);
      for (int n = 0; n < 40 && !out_valid; n++) tick();
      repeat (20) tick();
      chk("bp_out_data", out_data, C1_PT);
      chk("bp_in_ready", 128'(in_ready), 128'(0));
      chk("bp_busy", 128'(busy), 128'(1));
      out_ready = 1'b1;
      tick();
      chk("bp_release_in_ready", 128'(in_ready), 128'(1));
      chk("bp_release_busy", 128'(busy), 128'(0));

      // reset in the middle of a block
      send_block(C1_CT, C1_PT);
      repeat (4) tick();
      chk("mid_rk_idx_round5", 128'(rk_idx), 128'(5));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
      chk("mid_rst_out_data", out_data, 128'(0));
      chk("mid_rst_rk_idx", 128'(rk_idx), 128'(10));
      tick();
      rst_n = 1'b1;
      tick();
      send_block(C1_CT, C1_PT);
      wait_done(1'b0);
      chk("after_rst_plaintext", last_out, C1_PT);

      // back-to-back with the consumer always ready
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      out_ready = 1'b1;
      a0 = acc_count; h0 = hs_count;
      in_data = C1_CT; cur_pt = C1_PT; in_valid = 1'b1;
      for (int n = 0; n < 100 && acc_count < a0 + 4; n++) tick();
      in_valid = 1'b0;
      wait_done(1'b0);
      chk("b2b_accepts", 128'(acc_count - a0), 128'(4));
      chk("b2b_outputs", 128'(hs_count - h0), 128'(4));
      chk("b2b_spacing", 128'(last_space), 128'(12));
      chk("b2b_last_plaintext", last_out, C1_PT);
`ifdef AES_DEC_STATUS_EN
      chk("b2b_blk_cnt", 128'(blk_cnt), 128'(4));
`endif

      // random keys and blocks, random backpressure and key_ready drops while busy
      h0 = hs_count;
      for (int i = 0; i < 1000; i++) begin
         key = {$urandom, $urandom, $urandom, $urandom};
         pt  = {$urandom, $urandom, $urandom, $urandom};
         expand(key);
         ct = encrypt(pt);
         key_ready = 1'b1;
         send_block(ct, pt);
         key_ready = 1'($urandom_range(0, 1));
         wait_done(1'b1);
      end
      key_ready = 1'b1;
      chk("rand_outputs", 128'(hs_count - h0), 128'(1000));
      chk("final_queue_empty", 128'(exp_q.size()), 128'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
